// File: rtl/riscv_fwd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_fwd_pkg
//  Description : Shared types and constants for the forwarding / hazard
//                controller. The tracker entry stores destination indices
//                zero-extended to RD_MAX_W bits, so the entry type does not
//                depend on the instantiating module's REG_ADDR_W. That
//                parameter must not exceed RD_MAX_W.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_fwd_pkg;

  // Default register index width (32 architectural registers).
  localparam int REG_ADDR_W_DEF = 5;

  // Widest register index the tracker entry can hold.
  localparam int RD_MAX_W = 8;

  // Forward-select encoding for "no forwarding".
  localparam int unsigned SEL_REGFILE = 0;

  // One in-flight producer.
  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                wr;
    logic                is_load;
  } fwd_entry_t;

endpackage : riscv_fwd_pkg
`default_nettype wire

// File: rtl/fwd_match_prio.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_match_prio
//  Description : Youngest-producer search. Scans tracker stages
//                FIRST_STAGE..FWD_STAGES-1 for a valid register-writing entry
//                whose non-zero destination equals the non-zero address.
//                The lowest (youngest) stage index wins.
//  Ports       : entries - tracker vector, entry k = stage k
//                addr    - register index being read (zero-extended)
//                hit     - a matching producer exists
//                idx     - stage index of the youngest match (0 if no hit)
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_match_prio
  import riscv_fwd_pkg::*;
#(
  parameter int FWD_STAGES  = 3,
  parameter int FIRST_STAGE = 0,
  parameter int IDX_W       = 2
) (
  input  fwd_entry_t [FWD_STAGES-1:0] entries,
  input  logic [RD_MAX_W-1:0]         addr,
  output logic                        hit,
  output logic [IDX_W-1:0]            idx
);

  // Not every stage or field is inspected by every instance.
  logic unused_entries;
  assign unused_entries = ^entries;

  // Walk from oldest to youngest so the youngest match is the last written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = FWD_STAGES - 1; k >= FIRST_STAGE; k--) begin
      if (entries[k].valid && entries[k].wr && (entries[k].rd != '0) &&
          (entries[k].rd == addr) && (addr != '0)) begin
        hit = 1'b1;
        idx = IDX_W'(k);
      end
    end
  end

endmodule : fwd_match_prio
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_ctrl
//  Description : Forwarding and hazard controller. Tracks in-flight producers
//                in stages after ID (0=EX, 1=MEM, 2=WB, ...) and generates,
//                per read port, ID-stage (branch compare) and EX-stage (ALU)
//                forward selects, the load-use / branch stall and a
//                saturating stall counter.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                id_*            - instruction currently in ID
//                id_flush        - kill the ID instruction this cycle
//                pipe_hold       - global freeze, no stage advances
//                stall           - hold IF/ID, bubble into EX
//                id_fwd_sel      - per port: 0=regfile, k+1=output of stage k
//                ex_fwd_sel      - per port: 0=ID/EX operand, k=stage k reg
//                stall_cnt       - stall cycles taken, saturating
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_ctrl
  import riscv_fwd_pkg::*;
#(
  parameter int  NUM_PORTS  = 2,
  parameter int  REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int  FWD_STAGES = 3,
  parameter int  LOAD_STAGE = 1,
  localparam int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            id_valid,
  input  logic [NUM_PORTS*REG_ADDR_W-1:0] id_rs_addr,
  input  logic [NUM_PORTS-1:0]            id_rs_used,
  input  logic                            id_branch,
  input  logic [REG_ADDR_W-1:0]           id_rd,
  input  logic                            id_reg_write,
  input  logic                            id_is_load,
  input  logic                            id_flush,
  input  logic                            pipe_hold,
  output logic                            stall,
  output logic [NUM_PORTS*SEL_W-1:0]      id_fwd_sel,
  output logic [NUM_PORTS*SEL_W-1:0]      ex_fwd_sel,
  output logic [31:0]                     stall_cnt
);

  localparam logic [SEL_W-1:0] LOAD_K = SEL_W'(LOAD_STAGE);

  fwd_entry_t [FWD_STAGES-1:0]     trk;
  fwd_entry_t                      new_entry;
  logic [NUM_PORTS*REG_ADDR_W-1:0] ex_rs_addr;
  logic [NUM_PORTS-1:0]            ex_rs_used;
  logic [NUM_PORTS-1:0]            hazard;
  logic                            issue;

  assign stall = id_valid && !id_flush && (|hazard);
  assign issue = id_valid && !stall && !id_flush;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [RD_MAX_W-1:0] id_addr;
    logic [RD_MAX_W-1:0] ex_addr;
    logic                id_hit;
    logic                ex_hit;
    logic [SEL_W-1:0]    id_idx;
    logic [SEL_W-1:0]    ex_idx;
    logic                hit_is_load;
    logic                haz;
    logic [SEL_W-1:0]    id_sel;
    logic [SEL_W-1:0]    ex_sel;

    always_comb begin
      id_addr = '0;
      id_addr[REG_ADDR_W-1:0] = id_rs_addr[p*REG_ADDR_W +: REG_ADDR_W];
      ex_addr = '0;
      ex_addr[REG_ADDR_W-1:0] = ex_rs_addr[p*REG_ADDR_W +: REG_ADDR_W];
    end

    fwd_match_prio #(
      .FWD_STAGES (FWD_STAGES),
      .FIRST_STAGE(0),
      .IDX_W      (SEL_W)
    ) u_id_match (
      .entries(trk),
      .addr   (id_addr),
      .hit    (id_hit),
      .idx    (id_idx)
    );

    // EX consumers only take registered values, so stage 0 is excluded.
    fwd_match_prio #(
      .FWD_STAGES (FWD_STAGES),
      .FIRST_STAGE(1),
      .IDX_W      (SEL_W)
    ) u_ex_match (
      .entries(trk),
      .addr   (ex_addr),
      .hit    (ex_hit),
      .idx    (ex_idx)
    );

    // A branch at stage k needs k >= R (combinational outputs usable); an
    // ALU op meets the producer at k+1 next cycle and needs k+1 > R. Both
    // reduce to a hazard when k < R.
    always_comb begin
      hit_is_load = 1'b0;
      for (int k = 0; k < FWD_STAGES; k++) begin
        if (id_idx == SEL_W'(k)) hit_is_load = trk[k].is_load;
      end
      haz    = id_rs_used[p] && id_hit && (id_idx < (hit_is_load ? LOAD_K : '0));
      id_sel = (id_branch && id_rs_used[p] && id_hit) ? id_idx + SEL_W'(1)
                                                       : SEL_W'(SEL_REGFILE);
      ex_sel = (ex_rs_used[p] && ex_hit) ? ex_idx : SEL_W'(SEL_REGFILE);
    end

    assign hazard[p]                     = haz;
    assign id_fwd_sel[p*SEL_W +: SEL_W]  = id_sel;
    assign ex_fwd_sel[p*SEL_W +: SEL_W]  = ex_sel;
  end

  always_comb begin
    new_entry = '0;
    if (issue) begin
      new_entry.valid                = 1'b1;
      new_entry.rd[REG_ADDR_W-1:0]   = id_rd;
      new_entry.wr                   = id_reg_write;
      new_entry.is_load              = id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trk        <= '0;
      ex_rs_addr <= '0;
      ex_rs_used <= '0;
      stall_cnt  <= '0;
    end else if (!pipe_hold) begin
      trk[0] <= new_entry;
      for (int k = 1; k < FWD_STAGES; k++) begin
        trk[k] <= trk[k-1];
      end
      ex_rs_addr <= id_rs_addr;
      ex_rs_used <= issue ? id_rs_used : '0;
      if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule : fwd_hazard_ctrl
`default_nettype wire
